// File: rtl/io_ctrl_pkg.sv
// Shared mode encoding and button channel assignments for the board I/O front-end.
package io_ctrl_pkg;

  typedef enum logic {
    MODE_HALT = 1'b0,
    MODE_RUN  = 1'b1
  } mode_t;

  localparam int unsigned BTN_RUN  = 0;
  localparam int unsigned BTN_STEP = 1;

endpackage

// File: rtl/debouncer.sv
// One push-button channel: synchroniser, stability counter, debounced level and press pulse.
module debouncer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 500_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   w_pressed;
  logic                   w_differs;
  logic                   w_accept;

  assign w_pressed = ~r_sync[SYNC_STAGES-1];
  assign w_differs = (w_pressed != r_level);
  assign w_accept  = w_differs && (r_cnt == CNT_MAX);

  // Sync flops reset to the released (high) pin level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_n};
    end
  end

  // Press pulse is registered alongside the level so both appear in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= w_accept && w_pressed;
      if (!w_differs || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_level <= w_pressed;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/io_ctrl.sv
// Board I/O front-end: switch synchronisers, debounced buttons and the CPU clock-enable
// generator with RUN/HALT/single-step control.
module io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int unsigned N_BTN       = 3,
  parameter int unsigned SW_WIDTH    = 10,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 500_000,
  parameter int unsigned DIVISOR     = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn_n,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [SW_WIDTH-1:0] sw_sync,
  output logic [N_BTN-1:0]    btn_level,
  output logic [N_BTN-1:0]    btn_press,
  output logic                run,
  output logic                cpu_en
);

  localparam int unsigned DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIVISOR - 1);

  logic [SW_WIDTH-1:0] r_sw_sync [SYNC_STAGES];
  mode_t               r_mode;
  mode_t               w_mode_next;
  logic [DW-1:0]       r_div;
  logic [DW-1:0]       w_div_next;
  logic                r_cpu_en;
  logic                w_cpu_en_next;
  logic                w_toggle;
  logic                w_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sw_sync[i] <= '0;
      end
    end else begin
      r_sw_sync[0] <= sw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sw_sync[i] <= r_sw_sync[i-1];
      end
    end
  end

  assign sw_sync = r_sw_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    debouncer #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_btn_n(btn_n[g]),
      .o_level(btn_level[g]),
      .o_press(btn_press[g])
    );
  end

  assign w_toggle = btn_press[BTN_RUN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_HALT;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  always_comb begin
    w_mode_next = r_mode;
    if (w_toggle) begin
      w_mode_next = (r_mode == MODE_RUN) ? MODE_HALT : MODE_RUN;
    end
  end

  // A mode change in this cycle clears the divider and masks both step and divider pulses.
  always_comb begin
    w_step        = (r_mode == MODE_HALT) && btn_press[BTN_STEP] && !w_toggle;
    w_div_next    = '0;
    w_cpu_en_next = w_step;
    if ((r_mode == MODE_RUN) && !w_toggle) begin
      w_div_next = (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
      if (r_div == DIV_MAX) begin
        w_cpu_en_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_cpu_en <= 1'b0;
    end else begin
      r_div    <= w_div_next;
      r_cpu_en <= w_cpu_en_next;
    end
  end

  assign run    = (r_mode == MODE_RUN);
  assign cpu_en = r_cpu_en;

endmodule

// File: tb/tb_io_ctrl.sv
// Scoreboard bench for io_ctrl: expected press/cpu_en events are queued by cycle number
// and matched by a monitor that watches the pulse outputs.
module tb_io_ctrl;

  localparam int N_BTN    = 3;
  localparam int SW_WIDTH = 10;
  localparam int SYNC     = 2;
  localparam int DEB      = 4;
  localparam int DIV      = 5;
  localparam int K_CPU    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_BTN-1:0]    btn_n;
  logic [SW_WIDTH-1:0] sw;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [N_BTN-1:0]    btn_level;
  logic [N_BTN-1:0]    btn_press;
  logic                run;
  logic                cpu_en;

  io_ctrl #(
    .N_BTN      (N_BTN),
    .SW_WIDTH   (SW_WIDTH),
    .SYNC_STAGES(SYNC),
    .DEB_CYCLES (DEB),
    .DIVISOR    (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .sw       (sw),
    .sw_sync  (sw_sync),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .run      (run),
    .cpu_en   (cpu_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  function automatic void push_exp(int c, int k);
    int   i;
    ev_t  e;
    i = 0;
    e.cyc  = c;
    e.kind = k;
    while (i < sb.size() && (sb[i].cyc < c || (sb[i].cyc == c && sb[i].kind <= k))) i++;
    sb.insert(i, e);
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_cyc(int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: every pulse seen on btn_press/cpu_en must match the head of the scoreboard.
  initial begin : monitor
    logic hit;
    ev_t  e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        hit = (k == K_CPU) ? cpu_en : btn_press[k];
        if (hit) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", k, cyc);
          end else begin
            e = sb.pop_front();
            check($sformatf("event_kind@%0d", cyc), k, e.kind);
            check($sformatf("event_cycle_k%0d", k), cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int b;
    int r;
    rst   = 1'b1;
    btn_n = '1;
    sw    = 10'h155;
    repeat (3) @(posedge clk);
    #2;
    check("rst_run", run, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_btn_level", btn_level, 0);
    check("rst_btn_press", btn_press, 0);
    check("rst_sw_sync", sw_sync, 0);
    rst = 1'b0;
    sw  = '0;

    // Idle after reset
    b = cyc;
    at_cyc(b + 20);
    check("idle_run", run, 0);
    check("idle_btn_level", btn_level, 0);

    // Switch synchroniser latency
    b  = cyc;
    sw = 10'h2A5;
    at_cyc(b + 1);
    check("sw_sync_stage1", sw_sync, 0);
    at_cyc(b + 2);
    check("sw_sync_stage2", sw_sync, 10'h2A5);

    // Clean press on channel 2, then release
    b = cyc;
    btn_n[2] = 1'b0;
    push_exp(b + 6, 2);
    at_cyc(b + 5);
    check("ch2_level_before", btn_level, 0);
    at_cyc(b + 6);
    check("ch2_level_after", btn_level, 3'b100);
    at_cyc(b + 7);
    check("ch2_press_one_cycle", btn_press, 0);
    at_cyc(b + 10);
    btn_n[2] = 1'b1;
    at_cyc(b + 16);
    check("ch2_released", btn_level, 0);
    at_cyc(b + 20);

    // Bounce on channel 0
    b = cyc;
    btn_n[0] = 1'b0;
    at_cyc(b + 1); btn_n[0] = 1'b1;
    at_cyc(b + 2); btn_n[0] = 1'b0;
    at_cyc(b + 3); btn_n[0] = 1'b1;
    at_cyc(b + 15);
    check("bounce_run", run, 0);
    check("bounce_level", btn_level, 0);

    // Single step in HALT
    b = cyc;
    btn_n[1] = 1'b0;
    push_exp(b + 6, 1);
    push_exp(b + 7, K_CPU);
    at_cyc(b + 8);
    btn_n[1] = 1'b1;
    at_cyc(b + 20);
    check("step_still_halt", run, 0);

    // RUN, step ignored in RUN, then HALT dropping the pending pulse at R+20
    b = cyc;
    r = b + 7;
    btn_n[0] = 1'b0;
    push_exp(b + 6, 0);
    push_exp(r + 5, K_CPU);
    push_exp(r + 10, K_CPU);
    push_exp(r + 15, K_CPU);
    at_cyc(r - 1);
    check("run_before_rise", run, 0);
    at_cyc(r);
    check("run_rise", run, 1);
    at_cyc(b + 8);
    btn_n[0] = 1'b1;
    btn_n[1] = 1'b0;
    push_exp(b + 14, 1);
    at_cyc(b + 16);
    btn_n[1] = 1'b1;
    at_cyc(b + 20);
    btn_n[0] = 1'b0;
    push_exp(b + 26, 0);
    at_cyc(r + 19);
    check("run_before_halt", run, 1);
    at_cyc(r + 20);
    check("run_halted", run, 0);
    at_cyc(b + 28);
    btn_n[0] = 1'b1;
    at_cyc(b + 45);
    check("halt_stays", run, 0);

    // Simultaneous RUN+STEP in HALT, then reset at divider count 3
    b = cyc;
    r = b + 7;
    btn_n[1:0] = 2'b00;
    push_exp(b + 6, 0);
    push_exp(b + 6, 1);
    at_cyc(r);
    check("simul_run", run, 1);
    at_cyc(b + 8);
    btn_n[1:0] = 2'b11;
    at_cyc(r + 3);
    check("pre_rst_level", btn_level, 3'b011);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_run", run, 0);
    check("async_rst_cpu_en", cpu_en, 0);
    check("async_rst_level", btn_level, 0);
    check("async_rst_press", btn_press, 0);
    check("async_rst_sw_sync", sw_sync, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    b = cyc;
    at_cyc(b + 20);
    check("post_rst_halt", run, 0);
    check("post_rst_level", btn_level, 0);

    // Fresh RUN press after reset
    b = cyc;
    r = b + 7;
    btn_n[0] = 1'b0;
    push_exp(b + 6, 0);
    push_exp(r + 5, K_CPU);
    at_cyc(r);
    check("fresh_run", run, 1);
    at_cyc(b + 8);
    btn_n[0] = 1'b1;
    at_cyc(r + 7);

    if (sb.size() != 0) begin
      foreach (sb[i]) $display("pending event: kind %0d at cycle %0d", sb[i].kind, sb[i].cyc);
    end
    check("sb_pending", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
